pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
//  Parametrised pipeline-register chain for inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries an opaque DATA_W payload (packed control, operands, inst, rs/rt/rd) through DEPTH slices.
//  Each slice has its own valid bit. Stall holds every slice; flush kills the slices selected by
//  FLUSH_MASK. Provides occupancy and stall-length status for hazard and perf logic.
// PARAMETERS
//  DATA_W      32   payload width per slice, 1..256
//  DEPTH       1    number of register slices, 1..4; slice 0 is input side, DEPTH-1 drives out_*
//  FLUSH_MASK  'h1  DEPTH bits; bit i=1 -> slice i is invalidated by flush
//  STALL_CW    8    width of the saturating stall-length counter
// PORTS
//  clk        in   1                   pipeline clock; all state updates on falling edge
//  rst        in   1                   synchronous, active-high reset
//  in_valid   in   1                   payload at in_data is a real instruction
//  in_data    in   DATA_W              payload from the upstream stage
//  stall      in   1                   load-use or structural hazard; hold all slices
//  flush      in   1                   taken branch/jump/jr; kill FLUSH_MASK slices
//  out_valid  out  1                   valid bit of slice DEPTH-1
//  out_data   out  DATA_W              payload of slice DEPTH-1
//  occupancy  out  $clog2(DEPTH+1)     number of slices with valid=1
//  stall_len  out  STALL_CW            consecutive stalled edges, saturating
// BEHAVIOUR
//  - Reset (rst=1 at falling edge): all valid=0, all data=0, occupancy=0, stall_len=0. Reset
//    overrides stall and flush. Reset mid-stream discards every in-flight slice.
//  - Next-state terms use pre-edge values only. src(0)={in_valid,in_data}; src(i)=slice i-1.
//  - Per slice i at each falling edge, highest priority first:
//      1. flush & FLUSH_MASK[i] -> valid=0; data per PIPE_ZERO_ON_FLUSH_EN.
//      2. stall                 -> hold valid and data.
//      3. otherwise             -> load src(i).
//  - Unmasked slices obey stall normally during flush. If flush and stall are both high, masked
//    slices clear and unmasked slices hold.
//  - A masked slice that loads a flushed predecessor gets that predecessor's pre-edge contents.
//    Upstream must re-assert flush if the instruction must also die there.
//  - in_valid=0 with no stall inserts a bubble. Its data is still loaded but treated as
//    don't-care.
//  - Latency: DEPTH falling edges from in_* to out_*, with no stall. Throughput is 1 per cycle.
//  - occupancy is registered and reflects post-edge valid bits. Range is 0..DEPTH.
//  - stall_len: +1 on each edge with stall=1, clamped at 2^STALL_CW-1. It clears to 0 on any
//    edge with stall=0. flush does not affect it.
//  - out_* come straight from slice DEPTH-1 registers; there is no combinational path from in_*.
//  - Illegal: DEPTH outside 1..4, or FLUSH_MASK wider than DEPTH. Elaboration $error.
// CONFIGURATION
//  PIPE_ZERO_ON_FLUSH_EN defined: a flushed slice also forces data=0 (all-zero = nop encoding,
//    so a killed RegWr/MemWr is 0 even if a consumer ignores valid).
//  Undefined: a flushed slice clears only valid and data holds its old value. Fewer enables.
//    Consumers must gate every side effect with valid.
// TESTING
//  T1 reset: DEPTH=2, drive in_valid=1, in_data=32'hDEAD_BEEF, rst=1 for 2 edges
//     -> out_valid=0, out_data=0, occupancy=0, stall_len=0.
//  T2 latency: DEPTH=2, push A=32'h1111_0001 then B=32'h1111_0002
//     -> A at out_* after edge 2, B after edge 3, occupancy=2.
//  T3 stall: DEPTH=1, load 32'h0000_00AA, stall=1 for 3 edges while in_data=32'h55
//     -> out_data stays 32'hAA, stall_len=3. Stall drop -> 32'h55, stall_len=0.
//  T4 flush: DEPTH=2, FLUSH_MASK=2'b01, slices {X=32'h10, Y=32'h20} valid, flush=1
//     -> slice0 valid=0, out_data=32'h10 valid, occupancy=1.
//     Data zero vs hold per macro; run with and without PIPE_ZERO_ON_FLUSH_EN.
//  T5 flush+stall: DEPTH=2, FLUSH_MASK=2'b01, both high
//     -> slice0 invalid, slice1 holds its value, stall_len increments.
//  T6 saturation: STALL_CW=4, stall=1 for 20 edges -> stall_len=15, not wrapped.

Source files
------------

// File: rtl/pipe_stage_chain_if.sv
// Bundle of pipeline-chain signals between an upstream stage (master) and the
// register chain (slave); widths follow the chain's DATA_W/DEPTH/STALL_CW.
interface pipe_stage_chain_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 1,
  parameter int unsigned STALL_CW = 8
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                stall;
  logic                flush;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [OCC_W-1:0]    occupancy;
  logic [STALL_CW-1:0] stall_len;

  modport master (
    output in_valid, in_data, stall, flush,
    input  out_valid, out_data, occupancy, stall_len
  );

  modport slave (
    input  in_valid, in_data, stall, flush,
    output out_valid, out_data, occupancy, stall_len
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// DEPTH-slice pipeline register chain with per-slice valid, stall hold, masked flush,
// occupancy and saturating stall-length status. Updates on the falling clock edge.
// Optional macro PIPE_ZERO_ON_FLUSH_EN: flushed slices also zero their payload.
module pipe_stage_chain #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 1,
  parameter int unsigned FLUSH_MASK = 'h1,
  parameter int unsigned STALL_CW   = 8
) (
  input logic               clk,
  input logic               rst,
  pipe_stage_chain_if.slave bus
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be in 1..4");
  end
  if ((FLUSH_MASK >> DEPTH) != 0) begin : g_bad_mask
    $error("pipe_stage_chain: FLUSH_MASK wider than DEPTH");
  end

  logic [DEPTH-1:0]    valid_q, valid_d, src_valid, kill;
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DATA_W-1:0]   data_d [DEPTH];
  logic [DATA_W-1:0]   src_data [DEPTH];
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [STALL_CW-1:0] stall_len_q, stall_len_d;

  assign kill = bus.flush ? FLUSH_MASK[DEPTH-1:0] : '0;

  always_comb begin
    src_valid[0] = bus.in_valid;
    src_data[0]  = bus.in_data;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid_q[i-1];
      src_data[i]  = data_q[i-1];
    end
  end

  // Flush beats stall per slice, so masked slices clear while unmasked ones hold.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i];
      data_d[i]  = data_q[i];
      if (kill[i]) begin
        valid_d[i] = 1'b0;
`ifdef PIPE_ZERO_ON_FLUSH_EN
        data_d[i]  = '0;
`else
        data_d[i]  = data_q[i];
`endif
      end else if (!bus.stall) begin
        valid_d[i] = src_valid[i];
        data_d[i]  = src_data[i];
      end
    end
  end

  always_comb begin
    int unsigned cnt;
    cnt = 0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      cnt = cnt + 32'(valid_d[i]);
    end
    occ_d = OCC_W'(cnt);
  end

  always_comb begin
    stall_len_d = '0;
    if (bus.stall) begin
      stall_len_d = (&stall_len_q) ? stall_len_q : stall_len_q + 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      occ_q       <= '0;
      stall_len_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      occ_q       <= occ_d;
      stall_len_q <= stall_len_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.out_valid = valid_q[DEPTH-1];
  assign bus.out_data  = data_q[DEPTH-1];
  assign bus.occupancy = occ_q;
  assign bus.stall_len = stall_len_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a DEPTH=2 table plus DEPTH=1 stall/saturation sequences.
module tb_pipe_stage_chain;
  logic clk;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_chain_if #(.DATA_W(32), .DEPTH(2), .STALL_CW(8)) b2 ();
  pipe_stage_chain_if #(.DATA_W(32), .DEPTH(1), .STALL_CW(4)) b1 ();

  pipe_stage_chain #(.DATA_W(32), .DEPTH(2), .FLUSH_MASK(32'd1), .STALL_CW(8)) u_d2 (
    .clk(clk), .rst(rst), .bus(b2)
  );
  pipe_stage_chain #(.DATA_W(32), .DEPTH(1), .FLUSH_MASK(32'd1), .STALL_CW(4)) u_d1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

`ifdef PIPE_ZERO_ON_FLUSH_EN
  localparam logic [31:0] H1 = 32'h0;
  localparam logic [31:0] H2 = 32'h0;
  localparam logic [31:0] H3 = 32'h0;
`else
  localparam logic [31:0] H1 = 32'h10;
  localparam logic [31:0] H2 = 32'h40;
  localparam logic [31:0] H3 = 32'h66;
`endif

  typedef struct {
    logic        rst;
    logic        in_valid;
    logic [31:0] in_data;
    logic        stall;
    logic        flush;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [1:0]  exp_occ;
    logic [7:0]  exp_sl;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] d,
                              input logic st, input logic fl, input logic ev,
                              input logic [31:0] ed, input logic [1:0] eo,
                              input logic [7:0] es);
    vec_t v;
    v.rst = r; v.in_valid = iv; v.in_data = d; v.stall = st; v.flush = fl;
    v.exp_valid = ev; v.exp_data = ed; v.exp_occ = eo; v.exp_sl = es;
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic check(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    //           rst   iv    data          st    fl    ev    exp_data      occ    sl
    tbl[0]  = mk(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 8'd0);
    tbl[1]  = mk(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 8'd0);
    tbl[2]  = mk(1'b0, 1'b1, 32'h11110001, 1'b0, 1'b0, 1'b0, 32'h0,        2'd1, 8'd0);
    tbl[3]  = mk(1'b0, 1'b1, 32'h11110002, 1'b0, 1'b0, 1'b1, 32'h11110001, 2'd2, 8'd0);
    tbl[4]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h11110002, 2'd1, 8'd0);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        2'd0, 8'd0);
    tbl[6]  = mk(1'b0, 1'b1, 32'h20,       1'b0, 1'b0, 1'b0, 32'h0,        2'd1, 8'd0);
    tbl[7]  = mk(1'b0, 1'b1, 32'h10,       1'b0, 1'b0, 1'b1, 32'h20,       2'd2, 8'd0);
    tbl[8]  = mk(1'b0, 1'b1, 32'h99,       1'b0, 1'b1, 1'b1, 32'h10,       2'd1, 8'd0);
    tbl[9]  = mk(1'b0, 1'b0, 32'h77,       1'b0, 1'b0, 1'b0, H1,           2'd0, 8'd0);
    tbl[10] = mk(1'b0, 1'b1, 32'h30,       1'b0, 1'b0, 1'b0, 32'h77,       2'd1, 8'd0);
    tbl[11] = mk(1'b0, 1'b1, 32'h40,       1'b0, 1'b0, 1'b1, 32'h30,       2'd2, 8'd0);
    tbl[12] = mk(1'b0, 1'b1, 32'h50,       1'b1, 1'b1, 1'b1, 32'h30,       2'd1, 8'd1);
    tbl[13] = mk(1'b0, 1'b1, 32'h60,       1'b1, 1'b0, 1'b1, 32'h30,       2'd1, 8'd2);
    tbl[14] = mk(1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, H2,           2'd0, 8'd0);
    tbl[15] = mk(1'b0, 1'b1, 32'hC0,       1'b1, 1'b0, 1'b0, H2,           2'd0, 8'd1);
    tbl[16] = mk(1'b0, 1'b1, 32'hC1,       1'b0, 1'b0, 1'b0, 32'h0,        2'd1, 8'd0);
    tbl[17] = mk(1'b0, 1'b1, 32'hC2,       1'b1, 1'b0, 1'b0, 32'h0,        2'd1, 8'd1);
    tbl[18] = mk(1'b1, 1'b1, 32'hC3,       1'b1, 1'b1, 1'b0, 32'h0,        2'd0, 8'd0);

    b1.in_valid = 1'b0; b1.in_data = '0; b1.stall = 1'b0; b1.flush = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rst         = tbl[i].rst;
      b2.in_valid = tbl[i].in_valid;
      b2.in_data  = tbl[i].in_data;
      b2.stall    = tbl[i].stall;
      b2.flush    = tbl[i].flush;
      tick();
      check("d2_out_valid", i, 64'(b2.out_valid), 64'(tbl[i].exp_valid));
      check("d2_out_data",  i, 64'(b2.out_data),  64'(tbl[i].exp_data));
      check("d2_occupancy", i, 64'(b2.occupancy), 64'(tbl[i].exp_occ));
      check("d2_stall_len", i, 64'(b2.stall_len), 64'(tbl[i].exp_sl));
    end

    // DEPTH=1: load, hold under stall, release
    rst = 1'b0;
    b2.in_valid = 1'b0; b2.stall = 1'b0; b2.flush = 1'b0;
    b1.in_valid = 1'b1; b1.in_data = 32'hAA;
    tick();
    check("d1_load_valid", 0, 64'(b1.out_valid), 64'd1);
    check("d1_load_data",  0, 64'(b1.out_data),  64'hAA);
    check("d1_load_occ",   0, 64'(b1.occupancy), 64'd1);
    b1.in_data = 32'h55; b1.stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check("d1_stall_data", k, 64'(b1.out_data),  64'hAA);
      check("d1_stall_len",  k, 64'(b1.stall_len), 64'(k));
    end
    b1.stall = 1'b0;
    tick();
    check("d1_release_data", 0, 64'(b1.out_data),  64'h55);
    check("d1_release_len",  0, 64'(b1.stall_len), 64'd0);

    // 4-bit stall counter saturates at 15
    b1.in_data = 32'h66; b1.stall = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check("d1_sat_len", k, 64'(b1.stall_len), 64'((k > 15) ? 15 : k));
    end
    check("d1_sat_data", 0, 64'(b1.out_data), 64'h55);
    b1.stall = 1'b0;
    tick();
    check("d1_post_sat_len",  0, 64'(b1.stall_len), 64'd0);
    check("d1_post_sat_data", 0, 64'(b1.out_data),  64'h66);

    // flush of the only slice; in_data differs so the payload shows hold vs zero
    b1.in_data = 32'h77; b1.flush = 1'b1;
    tick();
    check("d1_flush_valid", 0, 64'(b1.out_valid), 64'd0);
    check("d1_flush_occ",   0, 64'(b1.occupancy), 64'd0);
    check("d1_flush_data",  0, 64'(b1.out_data),  64'(H3));
    b1.flush = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
